// File: rtl/apb_master_bridge_if.sv
// Command/response handshakes plus the APB master port of apb_master_bridge.
// The master modport is the bridge side; the slave modport is the environment side.
interface apb_master_bridge_if #(
    parameter int DW = 32,
    parameter int AW = 5
) ();
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [AW-1:0] i_cmd_addr;
    logic          i_cmd_write;
    logic [DW-1:0] i_cmd_wdata;

    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [DW-1:0] o_rsp_rdata;
    logic          o_rsp_err;

    logic [AW-1:0] o_paddr;
    logic          o_pwrite;
    logic          o_psel;
    logic          o_penable;
    logic [DW-1:0] o_pwdata;
    logic [DW-1:0] i_prdata;
    logic          i_pslverr;
    logic          i_pready;

    modport master (
        input  i_cmd_valid, i_cmd_addr, i_cmd_write, i_cmd_wdata,
        output o_cmd_ready,
        output o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  i_rsp_ready,
        output o_paddr, o_pwrite, o_psel, o_penable, o_pwdata,
        input  i_prdata, i_pslverr, i_pready
    );

    modport slave (
        output i_cmd_valid, i_cmd_addr, i_cmd_write, i_cmd_wdata,
        input  o_cmd_ready,
        input  o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output i_rsp_ready,
        input  o_paddr, o_pwrite, o_psel, o_penable, o_pwdata,
        output i_prdata, i_pslverr, i_pready
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding command-to-APB bridge: accept -> rsp_valid in 3 cycles plus PREADY waits.
// cmd_ready only in IDLE; response held until rsp_ready. APB_MASTER_TIMEOUT_EN adds an ACCESS abort timer.
module apb_master_bridge #(
    parameter int DW             = 32,
    parameter int AW             = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    apb_master_bridge_if.master bus
);

    if (AW < 1 || AW > 32) begin : g_bad_aw
        $error("apb_master_bridge: AW must be in 1..32");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic          pwrite_q, pwrite_d;
    logic [DW-1:0] pwdata_q, pwdata_d;
    logic          psel_q, psel_d;
    logic          penable_q, penable_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.i_cmd_valid) begin
                    paddr_d   = bus.i_cmd_addr;
                    pwrite_d  = bus.i_cmd_write;
                    pwdata_d  = bus.i_cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                if (bus.i_pready) begin
                    rsp_rdata_d = pwrite_q ? '0 : bus.i_prdata;
                    rsp_err_d   = bus.i_pslverr;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                // Abort on the TIMEOUT_CYCLES-th stalled ACCESS cycle.
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (bus.i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus.o_cmd_ready = (state_q == IDLE);
    assign bus.o_paddr     = paddr_q;
    assign bus.o_pwrite    = pwrite_q;
    assign bus.o_pwdata    = pwdata_q;
    assign bus.o_psel      = psel_q;
    assign bus.o_penable   = penable_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_rdata = rsp_rdata_q;
    assign bus.o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge; the slave side is driven by hand per step.
module tb_apb_master_bridge;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    apb_master_bridge_if #(.DW(32), .AW(5)) bus ();

    apb_master_bridge #(.DW(32), .AW(5), .TIMEOUT_CYCLES(16)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] addr, input logic wr, input logic [31:0] wdata);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_addr  = addr;
        bus.i_cmd_write = wr;
        bus.i_cmd_wdata = wdata;
    endtask

    initial begin
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_addr  = '0;
        bus.i_cmd_write = 1'b0;
        bus.i_cmd_wdata = '0;
        bus.i_rsp_ready = 1'b0;
        bus.i_prdata    = '0;
        bus.i_pslverr   = 1'b0;
        bus.i_pready    = 1'b0;

        // Reset state
        #2 rst = 1'b1;
        #2;
        check("rst_psel",      bus.o_psel, 0);
        check("rst_penable",   bus.o_penable, 0);
        check("rst_paddr",     bus.o_paddr, 0);
        check("rst_pwrite",    bus.o_pwrite, 0);
        check("rst_pwdata",    bus.o_pwdata, 0);
        check("rst_rsp_valid", bus.o_rsp_valid, 0);
        check("rst_rsp_rdata", bus.o_rsp_rdata, 0);
        check("rst_rsp_err",   bus.o_rsp_err, 0);
        check("rst_cmd_ready", bus.o_cmd_ready, 1);
        tick();
        tick();
        rst = 1'b0;

        // Write 0x08, zero-wait slave; pready already high in IDLE/SETUP must be ignored
        tick();
        send(5'h08, 1'b1, 32'hA5A5_0001);
        bus.i_pready = 1'b1;
        check("w1_cmd_ready", bus.o_cmd_ready, 1);
        tick();
        bus.i_cmd_valid = 1'b0;
        check("w1_setup_psel",    bus.o_psel, 1);
        check("w1_setup_penable", bus.o_penable, 0);
        check("w1_setup_paddr",   bus.o_paddr, 5'h08);
        check("w1_setup_pwrite",  bus.o_pwrite, 1);
        check("w1_setup_pwdata",  bus.o_pwdata, 32'hA5A5_0001);
        check("w1_setup_rdy",     bus.o_cmd_ready, 0);
        check("w1_setup_rvld",    bus.o_rsp_valid, 0);
        tick();
        check("w1_acc_psel",    bus.o_psel, 1);
        check("w1_acc_penable", bus.o_penable, 1);
        check("w1_acc_rvld",    bus.o_rsp_valid, 0);
        tick();
        check("w1_rsp_valid", bus.o_rsp_valid, 1);
        check("w1_rsp_psel",  bus.o_psel, 0);
        check("w1_rsp_pen",   bus.o_penable, 0);
        check("w1_rsp_err",   bus.o_rsp_err, 0);
        check("w1_rsp_rdata", bus.o_rsp_rdata, 0);
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
        check("w1_done_rvld",  bus.o_rsp_valid, 0);
        check("w1_done_rdy",   bus.o_cmd_ready, 1);
        check("w1_keep_paddr", bus.o_paddr, 5'h08);

        // Read 0x0C, one wait state, prdata 0xDEADBEEF
        send(5'h0C, 1'b0, 32'h0000_1234);
        bus.i_pready = 1'b0;
        bus.i_prdata = 32'hDEAD_BEEF;
        tick();
        bus.i_cmd_valid = 1'b0;
        check("r1_setup_psel",  bus.o_psel, 1);
        check("r1_setup_pen",   bus.o_penable, 0);
        check("r1_setup_paddr", bus.o_paddr, 5'h0C);
        check("r1_setup_pwr",   bus.o_pwrite, 0);
        tick();
        check("r1_acc1_pen",   bus.o_penable, 1);
        check("r1_acc1_paddr", bus.o_paddr, 5'h0C);
        tick();
        check("r1_acc2_psel",  bus.o_psel, 1);
        check("r1_acc2_pen",   bus.o_penable, 1);
        check("r1_acc2_rvld",  bus.o_rsp_valid, 0);
        check("r1_acc2_paddr", bus.o_paddr, 5'h0C);
        bus.i_pready = 1'b1;
        tick();
        check("r1_rsp_valid", bus.o_rsp_valid, 1);
        check("r1_rsp_rdata", bus.o_rsp_rdata, 32'hDEAD_BEEF);
        check("r1_rsp_err",   bus.o_rsp_err, 0);
        check("r1_rsp_psel",  bus.o_psel, 0);
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;

        // Write 0x0C with pslverr, then read 0x04 with pslverr
        send(5'h0C, 1'b1, 32'h0BAD_0BAD);
        bus.i_pslverr = 1'b1;
        bus.i_prdata  = 32'h5555_AAAA;
        tick();
        bus.i_cmd_valid = 1'b0;
        tick();
        tick();
        check("w2_rsp_valid", bus.o_rsp_valid, 1);
        check("w2_rsp_err",   bus.o_rsp_err, 1);
        check("w2_rsp_rdata", bus.o_rsp_rdata, 0);
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
        send(5'h04, 1'b0, 32'h0);
        tick();
        bus.i_cmd_valid = 1'b0;
        tick();
        tick();
        check("r2_rsp_valid", bus.o_rsp_valid, 1);
        check("r2_rsp_err",   bus.o_rsp_err, 1);
        check("r2_rsp_rdata", bus.o_rsp_rdata, 32'h5555_AAAA);
        bus.i_pslverr   = 1'b0;
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;

        // Response backpressure with a second command already waiting
        send(5'h10, 1'b1, 32'h0000_0011);
        tick();
        send(5'h14, 1'b0, 32'h0);
        bus.i_prdata = 32'hCAFE_0001;
        tick();
        tick();
        check("bp_rsp_valid", bus.o_rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", bus.o_rsp_valid, 1);
            check("bp_hold_rdata", bus.o_rsp_rdata, 0);
            check("bp_hold_err",   bus.o_rsp_err, 0);
            check("bp_hold_rdy",   bus.o_cmd_ready, 0);
            check("bp_hold_psel",  bus.o_psel, 0);
            tick();
        end
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
        check("bp_idle_rvld", bus.o_rsp_valid, 0);
        check("bp_idle_rdy",  bus.o_cmd_ready, 1);
        tick();
        bus.i_cmd_valid = 1'b0;
        check("bp_next_psel",  bus.o_psel, 1);
        check("bp_next_paddr", bus.o_paddr, 5'h14);
        check("bp_next_pwr",   bus.o_pwrite, 0);
        tick();
        tick();
        check("bp_next_rvld",  bus.o_rsp_valid, 1);
        check("bp_next_rdata", bus.o_rsp_rdata, 32'hCAFE_0001);
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;

        // Reset asserted during ACCESS
        send(5'h18, 1'b1, 32'h0000_0018);
        bus.i_pready = 1'b0;
        tick();
        bus.i_cmd_valid = 1'b0;
        tick();
        check("rm_acc_pen", bus.o_penable, 1);
        rst = 1'b1;
        #1;
        check("rm_psel",  bus.o_psel, 0);
        check("rm_pen",   bus.o_penable, 0);
        check("rm_rvld",  bus.o_rsp_valid, 0);
        check("rm_paddr", bus.o_paddr, 0);
        tick();
        rst = 1'b0;
        tick();
        check("rm_after_rdy",  bus.o_cmd_ready, 1);
        check("rm_after_psel", bus.o_psel, 0);

        // PREADY held low: timeout abort or indefinite wait
        send(5'h1C, 1'b0, 32'h0);
        bus.i_prdata = 32'h0000_0077;
        tick();
        bus.i_cmd_valid = 1'b0;
        tick();
`ifdef APB_MASTER_TIMEOUT_EN
        for (int c = 1; c <= 16; c++) begin
            check("to_wait_psel", bus.o_psel, 1);
            check("to_wait_pen",  bus.o_penable, 1);
            check("to_wait_rvld", bus.o_rsp_valid, 0);
            tick();
        end
        check("to_rsp_valid", bus.o_rsp_valid, 1);
        check("to_rsp_err",   bus.o_rsp_err, 1);
        check("to_rsp_rdata", bus.o_rsp_rdata, 0);
        check("to_rsp_psel",  bus.o_psel, 0);
        check("to_rsp_pen",   bus.o_penable, 0);
`else
        for (int c = 0; c < 100; c++) tick();
        check("nto_psel", bus.o_psel, 1);
        check("nto_pen",  bus.o_penable, 1);
        check("nto_rvld", bus.o_rsp_valid, 0);
        check("nto_rdy",  bus.o_cmd_ready, 0);
        bus.i_pready = 1'b1;
        tick();
        check("nto_late_rvld",  bus.o_rsp_valid, 1);
        check("nto_late_rdata", bus.o_rsp_rdata, 32'h0000_0077);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding command-to-APB master bridge; sits directly upstream of the APB register slave and drives its APB port.
- Accepts one read/write command on a valid/ready interface and runs a standard APB SETUP -> ACCESS transfer, waiting on PREADY.
- Returns read data and the slave error on a valid/ready response interface.
- Lets firmware-less control logic and testbenches reach the APB register map without hand-driving APB phases.

Parameters:
- DW, 32, data width; must match the slave.
- AW, 5, address width; at most 32.
- TIMEOUT_CYCLES, 16, ACCESS-phase cycles before abort. Used only with APB_MASTER_TIMEOUT_EN; minimum 2.

Ports:
- i_clk  input  1  clock
- i_reset  input  1  asynchronous, active-high reset
- i_cmd_valid  input  1  command valid
- o_cmd_ready  output  1  bridge can accept a command
- i_cmd_addr  input  AW  byte address
- i_cmd_write  input  1  1 = write, 0 = read
- i_cmd_wdata  input  DW  write data
- o_rsp_valid  output  1  response valid
- i_rsp_ready  input  1  response consumer ready
- o_rsp_rdata  output  DW  read data; 0 for writes
- o_rsp_err  output  1  PSLVERR (or timeout) of the completed transfer
- o_paddr  output  AW  APB address
- o_pwrite  output  1  APB write
- o_psel  output  1  APB select
- o_penable  output  1  APB enable
- o_pwdata  output  DW  APB write data
- i_prdata  input  DW  APB read data
- i_pslverr  input  1  APB slave error
- i_pready  input  1  APB ready

Behaviour:
- Reset (async, i_reset=1): state IDLE, o_psel=0, o_penable=0, o_paddr=0, o_pwrite=0, o_pwdata=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0.
- All outputs registered except o_cmd_ready, which is combinational: (state==IDLE).
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Command accepted on i_cmd_valid && o_cmd_ready.
  - Latch i_cmd_addr -> o_paddr, i_cmd_write -> o_pwrite, i_cmd_wdata -> o_pwdata.
  - Set o_psel=1, o_penable=0; go to SETUP.
- SETUP: exactly one cycle. Set o_penable=1; go to ACCESS.
- ACCESS:
  - Hold psel, penable, paddr, pwrite and pwdata stable.
  - On i_pready=1:
    - o_rsp_rdata = o_pwrite ? 0 : i_prdata.
    - o_rsp_err = i_pslverr.
    - o_psel=0, o_penable=0, o_rsp_valid=1; go to RESP.
  - i_pready and i_pslverr are ignored outside ACCESS.
- RESP:
  - Hold o_rsp_* until i_rsp_ready; on o_rsp_valid && i_rsp_ready, clear o_rsp_valid and go to IDLE.
  - o_paddr, o_pwrite and o_pwdata keep their last values after a transfer.
- Latency:
  - Zero-wait slave: command accept to o_rsp_valid = 3 cycles.
  - Each PREADY wait state adds 1 cycle.
  - Back-to-back commands are spaced at least 4 cycles apart (no pipelining; o_cmd_ready low during SETUP, ACCESS and RESP).
- Against the one-wait-state register slave: write completes in ACCESS cycle 1; read completes in ACCESS cycle 2.
- Reset mid-transfer: immediate return to IDLE, o_psel/o_penable drop asynchronously, any pending response is discarded.
- Reads and writes share the same path; no address decoding in the bridge.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with i_pready=0.
  - When it reaches TIMEOUT_CYCLES-1 with i_pready still low, the transfer aborts: o_psel=0, o_penable=0, o_rsp_err=1, o_rsp_rdata=0, o_rsp_valid=1, go to RESP.
  - Counter width is $clog2(TIMEOUT_CYCLES)+1.
- Without the macro: no counter; the bridge waits in ACCESS indefinitely for i_pready.

Test Plan:
- Write addr 0x08, data 0xA5A5_0001, slave pready in ACCESS cycle 1, pslverr=0 -> psel high 2 cycles, penable high 1 cycle, o_rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read addr 0x0C, slave returns 0xDEAD_BEEF with one wait state -> o_rsp_rdata=0xDEAD_BEEF, rsp_err=0, o_rsp_valid 4 cycles after accept; paddr stable throughout.
- Write addr 0x0C with pslverr=1 at pready -> o_rsp_err=1; a following read of 0x04 with pslverr=1 -> o_rsp_err=1, o_rsp_rdata=i_prdata.
- Hold i_rsp_ready=0 for 5 cycles after response while i_cmd_valid=1 -> response held stable, o_cmd_ready=0, no new psel; after i_rsp_ready=1, next command accepted the following cycle.
- Assert i_reset during ACCESS -> o_psel/o_penable/o_rsp_valid go 0 immediately; after release o_cmd_ready=1.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, i_pready held 0 -> abort after 16 ACCESS cycles, o_rsp_err=1, o_rsp_rdata=0. Without the macro -> still in ACCESS after 100 cycles.
